// File: rtl/ahb_slave_store.sv
// AHB-Lite slave write path: captures write address phases, lane-replicates
// LSB-justified HWDATA, generates byte enables and drives the RAM write port.
module ahb_slave_store #(
  parameter int unsigned RAM_AW      = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready,
  input  logic [31:0]       hwdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [1:0]          lane_q, lane_d;
  logic [2:0]          size_q, size_d;

  logic                can_accept;
  logic                accept;
  logic                misalign;
  logic [3:0]          be_c;
  logic [31:0]         wdata_c;
  logic                unused_bits;

  assign unused_bits = ^{haddr[31:RAM_AW+2], htrans[0]};

  // A new address phase can only overlap cycles where the slave drives ready high.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_WRITE) || (state_q == ST_ERR2);
  assign accept     = can_accept & hsel & hready & htrans[1] & hwrite;
  assign misalign   = (hsize > 3'b010) ||
                      ((hsize == 3'b001) && haddr[0]) ||
                      ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

  // Next-state, capture and response outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    size_d    = size_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    ram_we    = 1'b0;

    case (state_q)
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = ST_ERR2;
      end
      default: begin
        if (state_q == ST_WRITE) ram_we = 1'b1;
        if (state_q == ST_ERR2)  hresp  = 1'b1;
        state_d = ST_IDLE;
        if (accept) begin
          addr_d = haddr[RAM_AW+1:2];
          lane_d = haddr[1:0];
          size_d = hsize;
          if (misalign) begin
            state_d = ST_ERR1;
          end else if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
    endcase
  end

  // Lane steering from the captured size and byte offset.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = hwdata;
    case (size_q)
      3'b000: begin
        be_c    = 4'b0001 << lane_q;
        wdata_c = {4{hwdata[7:0]}};
      end
      3'b001: begin
        be_c    = 4'b0011 << {lane_q[1], 1'b0};
        wdata_c = {2{hwdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = hwdata;
      end
    endcase
  end

  assign ram_be    = ram_we ? be_c : 4'b0000;
  assign ram_wdata = ram_we ? wdata_c : 32'h0;
  assign ram_addr  = addr_q;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
    end
  end

endmodule

// File: tb/tb_ahb_slave_store.sv
// Directed bench for ahb_slave_store: three instances (0, 2 and 3 wait states)
// share the bus; a scoreboard queue holds the RAM writes each step expects.
module tb_ahb_slave_store;

  localparam int unsigned AW = 10;

  typedef struct {
    int          dut;
    logic [3:0]  be;
    logic [AW-1:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        hclk;
  logic        hresetn;
  logic        hsel0, hsel2, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  logic          ro0, ro2, ro3;
  logic          rs0, rs2, rs3;
  logic          we0, we2, we3;
  logic [3:0]    be0, be2, be3;
  logic [AW-1:0] ad0, ad2, ad3;
  logic [31:0]   wd0, wd2, wd3;

  wr_t sb[$];
  int  n_assert;
  int  n_fail;

  ahb_slave_store #(.RAM_AW(AW), .WAIT_CYCLES(0)) u0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(ro0), .hwdata(hwdata),
    .hreadyout(ro0), .hresp(rs0), .ram_we(we0), .ram_be(be0), .ram_addr(ad0),
    .ram_wdata(wd0));

  ahb_slave_store #(.RAM_AW(AW), .WAIT_CYCLES(2)) u2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(ro2), .hwdata(hwdata),
    .hreadyout(ro2), .hresp(rs2), .ram_we(we2), .ram_be(be2), .ram_addr(ad2),
    .ram_wdata(wd2));

  ahb_slave_store #(.RAM_AW(AW), .WAIT_CYCLES(3)) u3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(ro3), .hwdata(hwdata),
    .hreadyout(ro3), .hresp(rs3), .ram_we(we3), .ram_be(be3), .ram_addr(ad3),
    .ram_wdata(wd3));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [3:0] be, input logic [AW-1:0] a,
                      input logic [31:0] data);
    wr_t w;
    w.dut = d; w.be = be; w.addr = a; w.data = data;
    sb.push_back(w);
  endtask

  // Pops the scoreboard on every write strobe; idle ports must show zero lanes.
  task automatic mon_one(input int d, input logic we, input logic [3:0] be,
                         input logic [AW-1:0] a, input logic [31:0] data);
    wr_t w;
    if (we === 1'b1) begin
      chk($sformatf("write_expected_u%0d", d), 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        chk("write_dut", 32'(d), 32'(w.dut));
        chk("ram_be", 32'(be), 32'(w.be));
        chk("ram_addr", 32'(a), 32'(w.addr));
        chk("ram_wdata", data, w.data);
      end
    end else begin
      chk($sformatf("idle_be_u%0d", d), 32'(be), 32'd0);
      chk($sformatf("idle_wdata_u%0d", d), data, 32'd0);
    end
  endtask

  task automatic mid();
    @(negedge hclk);
    mon_one(0, we0, be0, ad0, wd0);
    mon_one(2, we2, be2, ad2, wd2);
    mon_one(3, we3, be3, ad3, wd3);
  endtask

  task automatic next();
    @(posedge hclk);
    #1;
  endtask

  task automatic drv(input int d, input logic [31:0] a, input logic [2:0] sz,
                     input logic wr, input logic [1:0] tr);
    hsel0 = (d == 0); hsel2 = (d == 2); hsel3 = (d == 3);
    haddr = a; hsize = sz; hwrite = wr; htrans = tr;
  endtask

  task automatic idle();
    hsel0 = 1'b0; hsel2 = 1'b0; hsel3 = 1'b0;
    haddr = 32'h0; hsize = 3'b000; hwrite = 1'b0; htrans = 2'b00;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    hresetn  = 1'b0;
    idle();
    hwdata   = 32'hDEAD_BEEF;

    // Reset state
    next(); next();
    mid();
    chk("rst_hreadyout", 32'(ro0), 32'd1);
    chk("rst_hresp", 32'(rs0), 32'd0);
    chk("rst_ram_we", 32'(we0), 32'd0);
    chk("rst_ram_addr", 32'(ad0), 32'd0);
    chk("rst_hreadyout_u3", 32'(ro3), 32'd1);
    next();
    hresetn = 1'b1;
    mid();
    next();

    // Byte store to 0x7
    drv(0, 32'h0000_0007, 3'b000, 1'b1, 2'b10);
    mid();
    chk("byte_addr_phase_ready", 32'(ro0), 32'd1);
    next();
    idle();
    hwdata = 32'h0000_00A5;
    push(0, 4'b1000, AW'(1), 32'hA5A5_A5A5);
    mid();
    chk("byte_we", 32'(we0), 32'd1);
    chk("byte_hreadyout", 32'(ro0), 32'd1);
    chk("byte_hresp", 32'(rs0), 32'd0);
    next();

    // Half store to 0x2
    drv(0, 32'h0000_0002, 3'b001, 1'b1, 2'b10);
    mid();
    next();
    idle();
    hwdata = 32'h0000_BEEF;
    push(0, 4'b1100, AW'(0), 32'hBEEF_BEEF);
    mid();
    chk("half_we", 32'(we0), 32'd1);
    next();

    // Word store with two wait states
    drv(2, 32'h0000_0010, 3'b010, 1'b1, 2'b10);
    mid();
    next();
    idle();
    hwdata = 32'h1234_5678;
    mid();
    chk("wait1_hreadyout", 32'(ro2), 32'd0);
    chk("wait1_we", 32'(we2), 32'd0);
    next();
    mid();
    chk("wait2_hreadyout", 32'(ro2), 32'd0);
    next();
    push(2, 4'b1111, AW'(4), 32'h1234_5678);
    mid();
    chk("wait_write_hreadyout", 32'(ro2), 32'd1);
    chk("wait_write_we", 32'(we2), 32'd1);
    next();
    mid();
    chk("wait_after_we", 32'(we2), 32'd0);
    next();

    // Misaligned word, then unsupported size accepted during ERR2
    drv(0, 32'h0000_0002, 3'b010, 1'b1, 2'b10);
    mid();
    next();
    idle();
    mid();
    chk("mis_err1_hresp", 32'(rs0), 32'd1);
    chk("mis_err1_hreadyout", 32'(ro0), 32'd0);
    next();
    drv(0, 32'h0000_0000, 3'b011, 1'b1, 2'b10);
    mid();
    chk("mis_err2_hresp", 32'(rs0), 32'd1);
    chk("mis_err2_hreadyout", 32'(ro0), 32'd1);
    next();
    idle();
    mid();
    chk("size_err1_hresp", 32'(rs0), 32'd1);
    chk("size_err1_hreadyout", 32'(ro0), 32'd0);
    next();
    mid();
    chk("size_err2_hresp", 32'(rs0), 32'd1);
    chk("size_err2_hreadyout", 32'(ro0), 32'd1);
    next();
    mid();
    chk("err_done_hresp", 32'(rs0), 32'd0);
    next();

    // Back-to-back byte stores, then an ignored read and an IDLE transfer
    drv(0, 32'h0000_0000, 3'b000, 1'b1, 2'b10);
    mid();
    next();
    drv(0, 32'h0000_0001, 3'b000, 1'b1, 2'b11);
    hwdata = 32'h0000_0011;
    push(0, 4'b0001, AW'(0), 32'h1111_1111);
    mid();
    next();
    drv(0, 32'h0000_0002, 3'b000, 1'b1, 2'b11);
    hwdata = 32'h0000_0022;
    push(0, 4'b0010, AW'(0), 32'h2222_2222);
    mid();
    chk("b2b_ready", 32'(ro0), 32'd1);
    next();
    drv(0, 32'h0000_0003, 3'b000, 1'b0, 2'b10);
    hwdata = 32'h0000_0033;
    push(0, 4'b0100, AW'(0), 32'h3333_3333);
    mid();
    next();
    drv(0, 32'h0000_0003, 3'b000, 1'b1, 2'b00);
    hwdata = 32'h0000_0044;
    mid();
    chk("read_no_we", 32'(we0), 32'd0);
    chk("read_ready", 32'(ro0), 32'd1);
    next();
    idle();
    mid();
    chk("idle_trans_no_we", 32'(we0), 32'd0);
    next();

    // Reset during the second wait cycle aborts the write
    drv(3, 32'h0000_0020, 3'b010, 1'b1, 2'b10);
    hwdata = 32'hCAFE_F00D;
    mid();
    next();
    idle();
    mid();
    chk("rst_wait1_hreadyout", 32'(ro3), 32'd0);
    next();
    hresetn = 1'b0;
    mid();
    chk("rst_wait2_hreadyout", 32'(ro3), 32'd0);
    next();
    hresetn = 1'b1;
    mid();
    chk("rst_abort_hreadyout", 32'(ro3), 32'd1);
    chk("rst_abort_we", 32'(we3), 32'd0);
    chk("rst_abort_addr", 32'(ad3), 32'd0);
    for (int i = 0; i < 6; i++) begin
      next();
      mid();
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
